// File: rtl/mul_seq_unit_if.sv
// Request/response bundle between the execute stage and the sequential multiplier.
interface mul_seq_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/mul_seq_unit.sv
// Shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU: sign-magnitude operands,
// one partial product per cycle, fixed latency of WIDTH+2 cycles from issue to done.
module mul_seq_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   mul_seq_unit_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               issue;
   logic               last_iter;
   logic               a_signed, b_signed;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc_fix;

   always_comb begin
      issue     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
      last_iter = (cnt_q == CW'(WIDTH - 1));
      a_signed  = (bus.op == 2'b01) || (bus.op == 2'b10);
      b_signed  = (bus.op == 2'b01);
      a_neg     = a_signed && bus.a[WIDTH-1];
      b_neg     = b_signed && bus.b[WIDTH-1];
      a_mag     = a_neg ? -bus.a : bus.a;
      b_mag     = b_neg ? -bus.b : bus.b;
      acc_fix   = neg_q ? -acc_q : acc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (issue) state_d = S_CALC;
         S_CALC:  if (last_iter) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = issue ? S_CALC : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == S_CALC) || (state_q == S_FIX);
      bus.done = (state_q == S_DONE);
   end

   assign bus.result = result_q;

   // The multiplicand register shifts left one place per iteration, which equals
   // shifting the captured value by the counter without a barrel shifter.
   always_comb begin
      op_d     = op_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      unique case (state_q)
         S_CALC: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
         end
         S_FIX: begin
            result_d = (op_q == 2'b00) ? acc_fix[WIDTH-1:0] : acc_fix[2*WIDTH-1:WIDTH];
         end
         default: ;
      endcase
      if (issue) begin
         op_d     = bus.op;
         mcand_d  = {{WIDTH{1'b0}}, a_mag};
         mplier_d = b_mag;
         neg_d    = a_neg ^ b_neg;
         acc_d    = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed-vector bench for mul_seq_unit: results, fixed latency, input isolation,
// back-to-back issue and asynchronous abort.
module tb_mul_seq_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [31:0] last_res;

   mul_seq_unit_if #(.WIDTH(32)) bus ();

   mul_seq_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge with the unit idle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
      int cyc;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_hold"}, bus.result, last_res);
      cyc = 1;
      while (!bus.done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_lat"}, 32'(cyc), 32'd34);
      check({tag, "_res"}, bus.result, exp);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      last_res = exp;
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int cyc;
      int busy_cycles;
      int dones;
      n_cmp     = 0;
      n_err     = 0;
      last_res  = '0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", bus.result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // First op also measures the busy window explicitly.
      bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      busy_cycles = 0;
      cyc         = 1;
      while (!bus.done && cyc < 100) begin
         if (bus.busy) busy_cycles++;
         @(posedge clk); #1;
         cyc++;
      end
      check("mul7x6_busy_cycles", 32'(busy_cycles), 32'd33);
      check("mul7x6_lat", 32'(cyc), 32'd34);
      check("mul7x6_res", bus.result, 32'h0000002A);
      check("mul7x6_idle", 32'(bus.busy), 32'd0);
      last_res = 32'h0000002A;
      @(posedge clk); #1;
      check("mul7x6_pulse", 32'(bus.done), 32'd0);

      run_op("mulh_min",    2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
      run_op("mul_min",     2'b00, 32'h80000000, 32'h80000000, 32'h00000000);
      run_op("mulhu_ones",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("mulh_ones",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      run_op("mul_ones",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run_op("mulhsu_ones", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mulh_m3x5",   2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF);
      run_op("mul_m3x5",    2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
      run_op("mulhsu_pos",  2'b10, 32'd5,        32'hFFFFFFFF, 32'h00000004);
      run_op("mulhu_zero",  2'b11, 32'd0,        32'hDEADBEEF, 32'h00000000);

      // Start held through the whole op; operand changes while busy must be ignored.
      bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.a = 32'd9; bus.b = 32'd9;
      cyc = 1;
      while (!bus.done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b_first_lat", 32'(cyc), 32'd34);
      check("b2b_first_res", bus.result, 32'd12);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b_relaunch_busy", 32'(bus.busy), 32'd1);
      check("b2b_relaunch_done", 32'(bus.done), 32'd0);
      check("b2b_hold", bus.result, 32'd12);
      cyc = 1;
      while (!bus.done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b_second_lat", 32'(cyc), 32'd34);
      check("b2b_second_res", bus.result, 32'd81);
      @(posedge clk); #1;
      check("b2b_pulse", 32'(bus.done), 32'd0);
      last_res = 32'd81;

      // Abort in CALC cycle 10 with an asynchronous reset.
      bus.op = 2'b00; bus.a = 32'h12345678; bus.b = 32'h10; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      check("abort_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_result", bus.result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      last_res = 32'd0;
      run_op("post_abort", 2'b00, 32'd2, 32'd3, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
